// File: rtl/morra_cinese_param.sv
// -----------------------------------------------------------------------------
// morra_cinese_param -- rock/paper/scissors ("morra cinese") game referee.
//
// Two players present a move on every clock. The block scores each round,
// tracks the score and the round count, and declares a game result. A game
// ends early when, after at least MIN_ROUNDS counted rounds, one player leads
// by LEAD or more. Otherwise it ends when the configured number of rounds has
// been played.
//
// Move encoding: 00 none, 01 rock, 10 paper, 11 scissors.
//
// Parameters
//   MIN_ROUNDS : added to the configured length; also the minimum number of
//                counted rounds before an early finish
//   LEAD       : score lead that ends the game early
//   CNT_W      : width of the round and score counters
//                (must satisfy 15 + MIN_ROUNDS < 2**CNT_W)
//
// Ports
//   clk           in   single clock, rising edge
//   INIZIA        in   synchronous active-high restart. It loads
//                      max_rounds = {PRIMO,SECONDO} + MIN_ROUNDS.
//   PRIMO[1:0]    in   player-1 move, or config high bits while INIZIA=1
//   SECONDO[1:0]  in   player-2 move, or config low bits while INIZIA=1
//   MANCHE[1:0]   out  round result: 00 invalid, 01 P1, 10 P2, 11 draw
//   PARTITA[1:0]  out  game result: 00 running, 01 P1, 10 P2, 11 draw
//   SCORE1        out  player-1 round wins (CNT_W bits)
//   SCORE2        out  player-2 round wins (CNT_W bits)
//   ROUNDS_PLAYED out  count of valid rounds (CNT_W bits)
//   o_dbg_state   out  FSM state for observation: 0 PLAY, 1 END
//
// All outputs are registered. They show the result of the inputs sampled at
// the same rising edge, so the latency is one edge.
//
// Build option
//   MORRA_REPEAT_BAN_EN : when defined, a player who wins a round may not
//   repeat the winning move on that player's next move. Such a move makes
//   the round invalid. A draw clears both bans, and an invalid round leaves
//   the bans unchanged. When the macro is undefined, no ban storage exists
//   and only 00 moves are invalid.
//
// Handshake: there is none. Every rising edge with INIZIA=0 presents one
// round attempt, and the outputs are valid from the edge after the first
// INIZIA onward.
// -----------------------------------------------------------------------------
module morra_cinese_param #(
  parameter int MIN_ROUNDS = 4,
  parameter int LEAD       = 2,
  parameter int CNT_W      = 5
) (
  input  logic             clk,
  input  logic             INIZIA,
  input  logic [1:0]       PRIMO,
  input  logic [1:0]       SECONDO,
  output logic [1:0]       MANCHE,
  output logic [1:0]       PARTITA,
  output logic [CNT_W-1:0] SCORE1,
  output logic [CNT_W-1:0] SCORE2,
  output logic [CNT_W-1:0] ROUNDS_PLAYED,
  output logic             o_dbg_state
);

  typedef enum logic {
    S_PLAY = 1'b0,
    S_END  = 1'b1
  } state_t;

  localparam logic [1:0] MV_ROCK     = 2'b01;
  localparam logic [1:0] MV_PAPER    = 2'b10;
  localparam logic [1:0] MV_SCISSORS = 2'b11;

  localparam logic [1:0] RES_NONE = 2'b00;
  localparam logic [1:0] RES_P1   = 2'b01;
  localparam logic [1:0] RES_P2   = 2'b10;
  localparam logic [1:0] RES_DRAW = 2'b11;

  localparam logic [CNT_W-1:0] C_MIN  = CNT_W'(MIN_ROUNDS);
  localparam logic [CNT_W-1:0] C_LEAD = CNT_W'(LEAD);
  localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

  // State registers.
  state_t           r_state;
  logic [CNT_W-1:0] r_max;
  logic [CNT_W-1:0] r_score1;
  logic [CNT_W-1:0] r_score2;
  logic [CNT_W-1:0] r_rounds;
  logic [1:0]       r_manche;
  logic [1:0]       r_partita;

  // Next-state values produced by the combinational process.
  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_score1_nxt;
  logic [CNT_W-1:0] w_score2_nxt;
  logic [CNT_W-1:0] w_rounds_nxt;
  logic [1:0]       w_manche_nxt;
  logic [1:0]       w_partita_nxt;

  // Round evaluation.
  logic             w_banned;
  logic             w_valid;
  logic             w_p1_wins;
  logic             w_draw;
  logic [CNT_W-1:0] w_cfg_max;
  logic [CNT_W-1:0] w_s1_upd;
  logic [CNT_W-1:0] w_s2_upd;
  logic [CNT_W-1:0] w_rounds_upd;
  logic [CNT_W-1:0] w_diff;
  logic             w_early_end;
  logic             w_full_end;
  logic [1:0]       w_leader;

  // The game length is loaded once per INIZIA. Because CNT_W is at least 4
  // by construction, the size cast is a plain zero-extension.
  assign w_cfg_max = CNT_W'({PRIMO, SECONDO}) + C_MIN;

`ifdef MORRA_REPEAT_BAN_EN
  // Banned move per player. 00 means no ban, because 00 is never a valid
  // move anyway.
  logic [1:0] r_ban1;
  logic [1:0] r_ban2;
  logic [1:0] w_ban1_nxt;
  logic [1:0] w_ban2_nxt;

  assign w_banned = ((r_ban1 != 2'b00) && (PRIMO   == r_ban1)) ||
                    ((r_ban2 != 2'b00) && (SECONDO == r_ban2));
`else
  assign w_banned = 1'b0;
`endif

  assign w_valid   = (PRIMO != 2'b00) && (SECONDO != 2'b00) && !w_banned;
  assign w_draw    = (PRIMO == SECONDO);
  assign w_p1_wins = ((PRIMO == MV_ROCK)     && (SECONDO == MV_SCISSORS)) ||
                     ((PRIMO == MV_SCISSORS) && (SECONDO == MV_PAPER))    ||
                     ((PRIMO == MV_PAPER)    && (SECONDO == MV_ROCK));

  // Candidate counters, assuming the round is valid. These cannot wrap,
  // because the game stops at r_max, which fits in CNT_W bits.
  assign w_s1_upd     = r_score1 + ((w_p1_wins) ? C_ONE : '0);
  assign w_s2_upd     = r_score2 + ((!w_p1_wins && !w_draw) ? C_ONE : '0);
  assign w_rounds_upd = r_rounds + C_ONE;

  // Unsigned magnitude of the score gap. Subtract the smaller value from
  // the larger one so the result never underflows.
  assign w_diff = (w_s1_upd >= w_s2_upd) ? (w_s1_upd - w_s2_upd)
                                         : (w_s2_upd - w_s1_upd);

  assign w_leader = (w_s1_upd > w_s2_upd) ? RES_P1 :
                    (w_s2_upd > w_s1_upd) ? RES_P2 : RES_DRAW;

  assign w_early_end = (w_rounds_upd >= C_MIN) && (w_diff >= C_LEAD);
  assign w_full_end  = (w_rounds_upd == r_max);

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt   = r_state;
    w_score1_nxt  = r_score1;
    w_score2_nxt  = r_score2;
    w_rounds_nxt  = r_rounds;
    w_manche_nxt  = RES_NONE;
    w_partita_nxt = r_partita;
`ifdef MORRA_REPEAT_BAN_EN
    w_ban1_nxt    = r_ban1;
    w_ban2_nxt    = r_ban2;
`endif
    case (r_state)
      S_PLAY: begin
        if (w_valid) begin
          w_score1_nxt = w_s1_upd;
          w_score2_nxt = w_s2_upd;
          w_rounds_nxt = w_rounds_upd;
          if (w_draw) begin
            w_manche_nxt = RES_DRAW;
          end else if (w_p1_wins) begin
            w_manche_nxt = RES_P1;
          end else begin
            w_manche_nxt = RES_P2;
          end
`ifdef MORRA_REPEAT_BAN_EN
          // Each player's pending ban applied to the move just made, so
          // any older ban is consumed. Only the winner receives a new ban.
          w_ban1_nxt = 2'b00;
          w_ban2_nxt = 2'b00;
          if (!w_draw && w_p1_wins) begin
            w_ban1_nxt = PRIMO;
          end else if (!w_draw) begin
            w_ban2_nxt = SECONDO;
          end
`endif
          if (w_early_end || w_full_end) begin
            w_partita_nxt = w_leader;
            w_state_nxt   = S_END;
          end
        end
      end
      S_END: begin
        // The result is frozen. Moves are ignored and MANCHE stays 00.
        w_state_nxt = S_END;
      end
      default: begin
        w_state_nxt = S_PLAY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (INIZIA) begin
      r_state   <= S_PLAY;
      r_max     <= w_cfg_max;
      r_score1  <= '0;
      r_score2  <= '0;
      r_rounds  <= '0;
      r_manche  <= RES_NONE;
      r_partita <= RES_NONE;
`ifdef MORRA_REPEAT_BAN_EN
      r_ban1    <= 2'b00;
      r_ban2    <= 2'b00;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_score1  <= w_score1_nxt;
      r_score2  <= w_score2_nxt;
      r_rounds  <= w_rounds_nxt;
      r_manche  <= w_manche_nxt;
      r_partita <= w_partita_nxt;
`ifdef MORRA_REPEAT_BAN_EN
      r_ban1    <= w_ban1_nxt;
      r_ban2    <= w_ban2_nxt;
`endif
    end
  end

  assign MANCHE        = r_manche;
  assign PARTITA       = r_partita;
  assign SCORE1        = r_score1;
  assign SCORE2        = r_score2;
  assign ROUNDS_PLAYED = r_rounds;
  assign o_dbg_state   = (r_state == S_END);

endmodule

// File: tb/tb_morra_cinese_param.sv
// -----------------------------------------------------------------------------
// tb_morra_cinese_param -- self-checking bench for morra_cinese_param
// (MIN_ROUNDS=4, LEAD=2, CNT_W=5).
//
// A game-level model computes the expected outputs from the rules of the
// game. Round winners come from modular move arithmetic, and the model keeps
// its scores in plain integers. A monitor compares every DUT output with the
// model on each falling edge once the first INIZIA has been applied. A set
// of hand-worked scenarios also pins literal values, both on the DUT and on
// the model.
// -----------------------------------------------------------------------------
module tb_morra_cinese_param;

  localparam int MIN_ROUNDS = 4;
  localparam int LEAD       = 2;
  localparam int CNT_W      = 5;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             INIZIA = 1'b0;
  logic [1:0]       PRIMO = 2'b00;
  logic [1:0]       SECONDO = 2'b00;
  logic [1:0]       MANCHE;
  logic [1:0]       PARTITA;
  logic [CNT_W-1:0] SCORE1;
  logic [CNT_W-1:0] SCORE2;
  logic [CNT_W-1:0] ROUNDS_PLAYED;
  logic             o_dbg_state;

  always #5 clk = ~clk;

  morra_cinese_param #(
    .MIN_ROUNDS(MIN_ROUNDS),
    .LEAD(LEAD),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .INIZIA(INIZIA),
    .PRIMO(PRIMO),
    .SECONDO(SECONDO),
    .MANCHE(MANCHE),
    .PARTITA(PARTITA),
    .SCORE1(SCORE1),
    .SCORE2(SCORE2),
    .ROUNDS_PLAYED(ROUNDS_PLAYED),
    .o_dbg_state(o_dbg_state)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_err    = 0;
  bit started  = 1'b0;

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_max, m_s1, m_s2, m_rounds, m_manche, m_partita;
  bit m_ended;
  int m_ban1, m_ban2;   // banned move per player, 0 = none

  // 0: draw, 1: player 1 wins, 2: player 2 wins.
  // Rock, paper and scissors map to 0, 1 and 2; each beats the one before it.
  function automatic int round_winner(input int a, input int b);
    return ((a - 1) - (b - 1) + 3) % 3;
  endfunction

  task automatic model_step(input bit init, input int p, input int s);
    int w, d;
    bit valid;
    if (init) begin
      m_max = p * 4 + s + MIN_ROUNDS;
      m_s1 = 0; m_s2 = 0; m_rounds = 0;
      m_manche = 0; m_partita = 0; m_ended = 0;
      m_ban1 = 0; m_ban2 = 0;
      return;
    end
    m_manche = 0;
    if (m_ended) return;
    valid = (p != 0) && (s != 0);
`ifdef MORRA_REPEAT_BAN_EN
    if ((m_ban1 != 0 && p == m_ban1) || (m_ban2 != 0 && s == m_ban2)) valid = 0;
`endif
    if (!valid) return;
    w = round_winner(p, s);
    m_rounds++;
    m_ban1 = 0; m_ban2 = 0;
    if (w == 0) m_manche = 3;
    else if (w == 1) begin m_manche = 1; m_s1++; m_ban1 = p; end
    else begin m_manche = 2; m_s2++; m_ban2 = s; end
    d = (m_s1 > m_s2) ? m_s1 - m_s2 : m_s2 - m_s1;
    if ((m_rounds >= MIN_ROUNDS && d >= LEAD) || m_rounds == m_max) begin
      m_ended = 1;
      m_partita = (m_s1 > m_s2) ? 1 : (m_s2 > m_s1) ? 2 : 3;
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input bit init, input logic [1:0] p, input logic [1:0] s);
    @(negedge clk);
    INIZIA  = init;
    PRIMO   = p;
    SECONDO = s;
    @(posedge clk);
    model_step(init, int'(p), int'(s));
    if (init) started = 1'b1;
    #1;
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (started) begin
      chk("manche",  int'(MANCHE),        m_manche);
      chk("partita", int'(PARTITA),       m_partita);
      chk("score1",  int'(SCORE1),        m_s1);
      chk("score2",  int'(SCORE2),        m_s2);
      chk("rounds",  int'(ROUNDS_PLAYED), m_rounds);
      chk("state",   int'(o_dbg_state),   int'(m_ended));
    end
  end

  // literal expectation on both the DUT value and the model
  task automatic lit(input string name, input int dut_v, input int mdl_v, input int exp);
    chk({name, "_dut"}, dut_v, exp);
    chk({name, "_model"}, mdl_v, exp);
  endtask

  localparam logic [1:0] R = 2'b01, P = 2'b10, S = 2'b11, N = 2'b00;

  // ---------------- stimulus ----------------
  initial begin
    // Startup: config 10/01 gives max 13.
    step(1'b1, 2'b10, 2'b01);
    lit("init_manche",  int'(MANCHE), m_manche, 0);
    lit("init_partita", int'(PARTITA), m_partita, 0);
    lit("init_score1",  int'(SCORE1), m_s1, 0);
    lit("init_rounds",  int'(ROUNDS_PLAYED), m_rounds, 0);
    chk("init_max_model", m_max, 13);
    step(1'b0, N, N);
    lit("none_manche", int'(MANCHE), m_manche, 0);
    lit("none_rounds", int'(ROUNDS_PLAYED), m_rounds, 0);
    step(1'b0, P, R);
    lit("pr_manche", int'(MANCHE), m_manche, 1);
    lit("pr_score1", int'(SCORE1), m_s1, 1);
    lit("pr_rounds", int'(ROUNDS_PLAYED), m_rounds, 1);

    // Early finish: max 5, P2 leads 3-1 after 4 rounds.
    step(1'b1, N, R);
    step(1'b0, R, P);
    lit("e1_manche", int'(MANCHE), m_manche, 2);
    step(1'b0, S, R);
    lit("e2_manche", int'(MANCHE), m_manche, 2);
    step(1'b0, P, S);
    lit("e3_manche", int'(MANCHE), m_manche, 2);
    lit("e3_partita", int'(PARTITA), m_partita, 0);
    step(1'b0, S, P);
    lit("e4_manche", int'(MANCHE), m_manche, 1);
    lit("e4_score1", int'(SCORE1), m_s1, 1);
    lit("e4_score2", int'(SCORE2), m_s2, 3);
    lit("e4_partita", int'(PARTITA), m_partita, 2);
    lit("e4_state", int'(o_dbg_state), int'(m_ended), 1);
    step(1'b0, R, S);
    lit("end_manche", int'(MANCHE), m_manche, 0);
    lit("end_score1", int'(SCORE1), m_s1, 1);

    // Repeat-ban behaviour.
    step(1'b1, 2'b11, 2'b11);
    step(1'b0, P, R);
    lit("ban1_manche", int'(MANCHE), m_manche, 1);
    step(1'b0, P, S);
`ifdef MORRA_REPEAT_BAN_EN
    lit("ban2_manche", int'(MANCHE), m_manche, 0);
    lit("ban2_rounds", int'(ROUNDS_PLAYED), m_rounds, 1);
`else
    lit("ban2_manche", int'(MANCHE), m_manche, 2);
    lit("ban2_rounds", int'(ROUNDS_PLAYED), m_rounds, 2);
`endif

    // Max 4 with all draws.
    step(1'b1, N, N);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, R, R);
      lit("draw_manche", int'(MANCHE), m_manche, 3);
      lit("draw_partita", int'(PARTITA), m_partita, (i == 3) ? 3 : 0);
    end
    step(1'b0, P, R);
    lit("drawend_manche", int'(MANCHE), m_manche, 0);
    lit("drawend_partita", int'(PARTITA), m_partita, 3);

    // Mid-game restart at 2-1, then 19 draws.
    step(1'b1, N, R);
    step(1'b0, P, R);
    step(1'b0, S, R);
    step(1'b0, R, S);
    lit("mid_score1", int'(SCORE1), m_s1, 2);
    lit("mid_score2", int'(SCORE2), m_s2, 1);
    step(1'b1, S, S);
    lit("rst_score1", int'(SCORE1), m_s1, 0);
    lit("rst_rounds", int'(ROUNDS_PLAYED), m_rounds, 0);
    lit("rst_partita", int'(PARTITA), m_partita, 0);
    chk("rst_max_model", m_max, 19);
    for (int i = 1; i <= 19; i++) begin
      step(1'b0, S, S);
      if (i == 18) lit("long18_partita", int'(PARTITA), m_partita, 0);
    end
    lit("long19_partita", int'(PARTITA), m_partita, 3);
    lit("long19_rounds", int'(ROUNDS_PLAYED), m_rounds, 19);

    // Randomized games with occasional mid-game restarts.
    for (int g = 0; g < 60; g++) begin
      step(1'b1, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      for (int k = 0; k < 26; k++) begin
        if ($urandom_range(0, 49) == 0)
          step(1'b1, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
        else if ($urandom_range(0, 5) == 0)
          step(1'b0, N, 2'($urandom_range(0, 3)));
        else
          step(1'b0, 2'($urandom_range(1, 3)), 2'($urandom_range(1, 3)));
      end
    end

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
